instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RISC-V instruction encoder and instruction-memory writer: accepts decoded instruction fields (opcode, registers, funct, immediate) over a valid/ready handshake, packs them into 32-bit R/I/S/B/J-format words, and writes them to consecutive instruction-memory words. It is the inverse of the opcode-to-control decode path. It sits between the testbench or program-loader front end and the instruction-memory write port, and loads programs before the core is released from reset.

## Interface
- ADDR_W, 6: instruction-memory word-address width; depth = 2^ADDR_W words.
- clk  in  1  clock, all logic on rising edge.
- arst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  block can accept a tuple.
- in_opcode  in  7  RISC-V opcode[6:0].
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3; in_funct7  in  7.
- in_imm  in  21  signed immediate. Bits used per format: I/S [11:0], B [12:1], J [20:1].
- in_last  in  1  tuple is the final instruction of the program.
- clear  in  1  leave DONE, reset write pointer.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  program load complete.
- count  out  ADDR_W+1  instructions written since reset or clear.
- enc_err  out  1  sticky illegal-opcode flag. Present only with the macro.

## Operation
- State machine:
  - IDLE: in_ready=1. On in_valid: latch all fields and in_last, go to ENC.
  - ENC: register the encoded word into imem_wdata, go to WR.
  - WR: imem_we=1, imem_addr=ptr. Then ptr += 1 and count += 1.
    - Go to DONE if the latched last flag is set or ptr was 2^ADDR_W-1.
    - Otherwise go to IDLE.
  - DONE: done=1, in_ready=0. On clear: ptr=0, count=0, go to IDLE.
- Encoding by opcode:
  - 0110011 (R): {funct7,rs2,rs1,funct3,rd,op}.
  - 0010011 (ALU-I) and 0000011 (LOAD): {imm[11:0],rs1,funct3,rd,op}.
  - 0100011 (STORE): {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
  - 1100011 (BRANCH): {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}. imm[0] is ignored.
  - 1101111 (JAL): {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}. imm[0] is ignored.
  - Any other opcode: see Configuration.
- Immediate bits outside the format's range are ignored. No range check.
- Full: the write at address 2^ADDR_W-1 forces DONE even if in_last=0. The pointer never wraps silently. count reaches 2^ADDR_W.
- Reset values: in_ready=0 during reset and 1 in the first cycle after reset. All other outputs 0: imem_we, imem_addr, imem_wdata, busy, done, count, enc_err. State IDLE.
- Reset mid-operation (ENC or WR): the in-flight instruction is dropped, no write occurs, ptr=0.
- clear outside DONE is ignored.

## Timing
- Tuple accepted on edge N (in_valid and in_ready). imem_we is high in cycle N+2, with addr and wdata stable in that cycle.
- Throughput: one instruction per 3 cycles. in_ready is low in ENC, WR and DONE.
- done rises in the cycle after the final WR and holds until clear.
- clear and in_valid high together in DONE: clear wins. No accept in that cycle. in_ready rises the next cycle.
- in_valid deasserted in IDLE has no effect; there is no timeout.

## Configuration
- Macro INSTR_ENC_CHECK_EN.
- Defined:
  - An unsupported opcode writes 0x00000013 (nop) at the normal address.
  - enc_err is set sticky in the WR cycle and cleared only by reset or clear.
- Undefined:
  - An unsupported opcode is packed in R-format layout from the raw fields.
  - The enc_err port does not exist.

## Test plan
- add x3,x1,x2 (op 0110011, f3 0, f7 0), in_last=0 -> imem_we at N+2, addr 0, wdata 0x002081B3, count 1, back in IDLE.
- Sequence with last on the 4th tuple:
  - addi x5,x0,10 -> 0x00A00293 @0.
  - lw x6,4(x5) -> 0x0042A303 @1.
  - sw x6,8(x5) -> 0x0062A423 @2.
  - beq x1,x2,-8 -> 0xFE208CE3 @3.
  - Then done=1 and count=4.
- jal x1,16 with in_last=1 -> 0x010000EF @0, done=1. Then in_valid plus clear together -> no accept; next tuple written at addr 0.
- ADDR_W=2, four tuples with in_last=0 -> writes at 0..3, DONE after the 4th, count=4, in_ready=0, a 5th in_valid is ignored.
- Opcode 0x7F with macro defined -> wdata 0x00000013, enc_err=1 until clear. Without the macro -> R-format packing of the raw fields.
- arst_n low during WR -> no imem_we; after release all outputs 0 except in_ready=1; the next tuple is written at addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RISC-V instruction fields (R/I/S/B/J formats)
// into 32-bit words and writes them to consecutive instruction-memory
// addresses. It is used to load a program before the core leaves reset.
// Each instruction takes three cycles: accept (IDLE), encode (ENC) and
// write (WR).
// The optional macro INSTR_ENC_CHECK_EN changes how unsupported opcodes are
// handled. When it is defined, an unsupported opcode is replaced by a nop and
// the sticky enc_err flag is raised. When it is undefined, the raw fields are
// packed in R-format layout and the enc_err port does not exist.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [20:0]       in_imm,
    input  logic              in_last,
    input  logic              clear,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
`ifdef INSTR_ENC_CHECK_EN
    output logic              enc_err,
`endif
    output logic [ADDR_W:0]   count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r;
    logic [6:0]          op_r;
    logic [4:0]          rd_r;
    logic [4:0]          rs1_r;
    logic [4:0]          rs2_r;
    logic [2:0]          f3_r;
    logic [6:0]          f7_r;
    logic [20:0]         imm_r;
    logic                last_r;
    logic [ADDR_W-1:0]   ptr_r;
    logic                imem_we_r;
    logic [31:0]         enc_word_s;
`ifdef INSTR_ENC_CHECK_EN
    logic                illegal_s;
`endif

    // True for the opcodes this encoder knows how to pack.
    function automatic logic is_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: ok = 1'b1;
            default:                                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pack the latched fields into the instruction format selected by opcode.
    function automatic logic [31:0] encode(
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [20:0] imm
    );
        logic [31:0] w;
        case (op)
            OP_R:             w = {f7, rs2, rs1, f3, rd, op};
            OP_ALUI, OP_LOAD: w = {imm[11:0], rs1, f3, rd, op};
            OP_STORE:         w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            OP_BRANCH:        w = {imm[12], imm[10:5], rs2, rs1, f3,
                                   imm[4:1], imm[11], op};
            OP_JAL:           w = {imm[20], imm[10:1], imm[11], imm[19:12],
                                   rd, op};
`ifdef INSTR_ENC_CHECK_EN
            default:          w = NOP_WORD;
`else
            default:          w = {f7, rs2, rs1, f3, rd, op};
`endif
        endcase
        return w;
    endfunction

    // Encoded word for the instruction currently held in the field latches.
    always_comb begin
        enc_word_s = encode(op_r, rd_r, rs1_r, rs2_r, f3_r, f7_r, imm_r);
    end

`ifdef INSTR_ENC_CHECK_EN
    // Flag the held instruction as one the encoder cannot represent.
    always_comb begin
        if (is_supported(op_r)) begin
            illegal_s = 1'b0;
        end else begin
            illegal_s = 1'b1;
        end
    end
`endif

    // The block is ready only in IDLE and never while reset is held. The write
    // strobe is masked by reset so that an instruction caught in WR is dropped.
    assign in_ready = (state_r == ST_IDLE) & arst_n;
    assign imem_we  = imem_we_r & arst_n;

    // Sequencer: accept -> encode -> write, then either idle or done.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_r    <= ST_IDLE;
            op_r       <= 7'd0;
            rd_r       <= 5'd0;
            rs1_r      <= 5'd0;
            rs2_r      <= 5'd0;
            f3_r       <= 3'd0;
            f7_r       <= 7'd0;
            imm_r      <= 21'd0;
            last_r     <= 1'b0;
            ptr_r      <= '0;
            imem_we_r  <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
`ifdef INSTR_ENC_CHECK_EN
            enc_err    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r    <= in_opcode;
                        rd_r    <= in_rd;
                        rs1_r   <= in_rs1;
                        rs2_r   <= in_rs2;
                        f3_r    <= in_funct3;
                        f7_r    <= in_funct7;
                        imm_r   <= in_imm;
                        last_r  <= in_last;
                        busy    <= 1'b1;
                        state_r <= ST_ENC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ENC: begin
                    imem_wdata <= enc_word_s;
                    imem_addr  <= ptr_r;
                    imem_we_r  <= 1'b1;
`ifdef INSTR_ENC_CHECK_EN
                    if (illegal_s) begin
                        enc_err <= 1'b1;
                    end else begin
                        enc_err <= enc_err;
                    end
`endif
                    state_r    <= ST_WR;
                end
                ST_WR: begin
                    imem_we_r <= 1'b0;
                    ptr_r     <= ptr_r + ADDR_W'(1);
                    count     <= count + (ADDR_W+1)'(1);
                    busy      <= 1'b0;
                    // The top address ends the load so the pointer never wraps.
                    if (last_r || (ptr_r == {ADDR_W{1'b1}})) begin
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (clear) begin
                        ptr_r   <= '0;
                        count   <= '0;
                        done    <= 1'b0;
`ifdef INSTR_ENC_CHECK_EN
                        enc_err <= 1'b0;
`endif
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes the expected write
// (address, word, cycle) when it issues a tuple, and the monitor pops and
// compares on every imem_we. Random tuples are checked against a shift/mask
// reference encoder.
module tb_instr_encoder;

    localparam int AW = 6;

    logic          clk;
    logic          arst_n;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [20:0]   in_imm;
    logic          in_last;
    logic          clear;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
`ifdef INSTR_ENC_CHECK_EN
    logic          enc_err;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   mptr     = 0;
    int   mcount   = 0;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .clear      (clear),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
`ifdef INSTR_ENC_CHECK_EN
        .enc_err    (enc_err),
`endif
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference encoder built from the format bit maps with shifts and masks.
    function automatic logic [31:0] enc_model(input int unsigned op, input int unsigned rd,
                                              input int unsigned rs1, input int unsigned rs2,
                                              input int unsigned f3, input int unsigned f7,
                                              input int unsigned imm);
        int unsigned base_r;
        base_r = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        case (op)
            32'h33: return base_r;
            32'h13, 32'h03:
                return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            32'h23:
                return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) |
                       (f3 << 12) | ((imm & 32'h1F) << 7) | op;
            32'h63:
                return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                       (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                       (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | op;
            32'h6F:
                return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                       (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                       (rd << 7) | op;
`ifdef INSTR_ENC_CHECK_EN
            default: return 32'h0000_0013;
`else
            default: return base_r;
`endif
        endcase
    endfunction

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
                chk("wr_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
`ifdef INSTR_ENC_CHECK_EN
        chk("rst_enc_err", 32'(enc_err), 32'd0);
`endif
    endtask

    // Hold reset for two edges (arst_n already low), then release and check.
    task automatic finish_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        chk("we_in_reset", 32'(imem_we), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        exp_q.delete();
        mptr   = 0;
        mcount = 0;
        @(negedge clk);
        chk_reset_outputs();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        arst_n = 1'b0;
        finish_reset();
    endtask

    // Wait (bounded) for in_ready and present one tuple; returns just after the accept edge.
    task automatic present(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [20:0] imm, input logic last, output bit ok, output int acc);
        int n;
        n  = 0;
        ok = 1'b0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
            in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
            in_valid  = 1'b1;
            acc       = cyc;
            ok        = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [20:0] imm, input logic last, input logic [31:0] exp_word);
        bit ok;
        int acc;
        exp_t e;
        present(op, rd, rs1, rs2, f3, f7, imm, last, ok, acc);
        if (ok) begin
            e.addr = AW'(mptr);
            e.data = exp_word;
            e.cyc  = acc + 2;
            exp_q.push_back(e);
            mptr   = (mptr + 1) % (1 << AW);
            mcount = mcount + 1;
        end
    endtask

    task automatic send_rand(input logic last);
        logic [6:0]  ops [8];
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [20:0] imm;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h13};
        op  = ops[$urandom_range(0, 7)];
        if ($urandom_range(0, 15) == 0) op = 7'($urandom);
        rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        f3  = 3'($urandom); f7  = 7'($urandom); imm = 21'($urandom);
        send(op, rd, rs1, rs2, f3, f7, imm, last,
             enc_model(32'(op), 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7), 32'(imm)));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 12) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("done", 32'(done), 32'd1);
        chk("done_count", 32'(count), 32'(mcount));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_done();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        mptr   = 0;
        mcount = 0;
        @(negedge clk);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
`ifdef INSTR_ENC_CHECK_EN
        chk("clr_enc_err", 32'(enc_err), 32'd0);
`endif
    endtask

    initial begin
        bit ok;
        int acc;
        arst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; in_last = 1'b0;
        in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 21'd0;
        finish_reset();

        // Single R-type, not last: written at 0, then back to IDLE.
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, 1'b0, 32'h002081B3);
        repeat (3) @(negedge clk);
        chk("add_count", 32'(count), 32'd1);
        chk("add_idle_ready", 32'(in_ready), 32'd1);
        chk("add_idle_busy", 32'(busy), 32'd0);
        chk("add_idle_done", 32'(done), 32'd0);

        // Four-instruction program.
        apply_reset();
        send(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 21'd10, 1'b0, 32'h00A00293);
        send(7'h03, 5'd6, 5'd5, 5'd0, 3'd2, 7'd0, 21'd4, 1'b0, 32'h0042A303);
        send(7'h23, 5'd0, 5'd5, 5'd6, 3'd2, 7'd0, 21'd8, 1'b0, 32'h0062A423);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'h1FFFF8, 1'b1, 32'hFE208CE3);
        wait_done();

        // JAL as a one-instruction program, then clear racing in_valid.
        clear_done();
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd16, 1'b1, 32'h010000EF);
        wait_done();
        @(negedge clk);
        in_opcode = 7'h33; in_valid = 1'b1; clear = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; clear = 1'b0;
        mptr = 0; mcount = 0;
        @(negedge clk);
        chk("clr_vs_valid_busy", 32'(busy), 32'd0);
        chk("clr_vs_valid_ready", 32'(in_ready), 32'd1);
        chk("clr_vs_valid_done", 32'(done), 32'd0);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, 1'b1, 32'h002081B3);
        wait_done();

        // Unsupported opcode.
        clear_done();
        send(7'h7F, 5'd9, 5'd10, 5'd11, 3'd5, 7'h2A, 21'd0, 1'b1,
`ifdef INSTR_ENC_CHECK_EN
             32'h0000_0013);
`else
             {7'h2A, 5'd11, 5'd10, 3'd5, 5'd9, 7'h7F});
`endif
        wait_done();
`ifdef INSTR_ENC_CHECK_EN
        chk("enc_err_set", 32'(enc_err), 32'd1);
        repeat (3) @(negedge clk);
        chk("enc_err_sticky", 32'(enc_err), 32'd1);
`endif

        // Fill every address with in_last=0: must stop at the top address.
        clear_done();
        for (int i = 0; i < (1 << AW); i++) send_rand(1'b0);
        wait_done();
        chk("full_count", 32'(count), 32'(1 << AW));
        @(negedge clk);
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("full_ignore_busy", 32'(busy), 32'd0);
        chk("full_ignore_count", 32'(count), 32'(1 << AW));
        in_valid = 1'b0;

        // Random programs ending with in_last.
        for (int p = 0; p < 3; p++) begin
            int len;
            clear_done();
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) send_rand(k == len - 1);
            wait_done();
        end

        // Reset asserted while an instruction is in WR: dropped, pointer back to 0.
        clear_done();
        send_rand(1'b0);
        repeat (3) @(negedge clk);
        present(7'h33, 5'd7, 5'd8, 5'd9, 3'd1, 7'd0, 21'd0, 1'b0, ok, acc);
        @(posedge clk);
        #1 arst_n = 1'b0;
        finish_reset();
        send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 21'h7FF, 1'b1, 32'h7FF10093);
        wait_done();

        repeat (5) @(negedge clk);
        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
